ft245_ctrl: RTL and testbench

Sequencer for the FT245-style USB FIFO attached to the 68000 board glue.
- Accepts byte-write requests (TX) and byte-read requests (RX) from the CPU-side bus logic.
- Arbitrates between them and generates the FIFO strobes (wr active-high, _rd active-low) with parameterised pulse widths and recovery time.
- Drives and samples the shared 8-bit FIFO data bus with an explicit output enable.

---
 rtl/ft245_ctrl_if.sv | 28 ++
 rtl/ft245_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ft245_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft245_ctrl_if.sv
// Bus bundle between the CPU-side glue, the FT245 sequencer and the USB FIFO pins.
// slave = sequencer view, master = CPU/FIFO environment view.
interface ft245_ctrl_if;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic       rx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       _txe;
    logic       _rdf;
    logic       wr;
    logic       _rd;
    logic [7:0] d_out;
    logic       d_oe;
    logic [7:0] d_in;

    modport slave (
        input  tx_req, tx_data, rx_req, _txe, _rdf, d_in,
        output tx_ack, rx_data, rx_valid, busy, wr, _rd, d_out, d_oe
    );

    modport master (
        output tx_req, tx_data, rx_req, _txe, _rdf, d_in,
        input  tx_ack, rx_data, rx_valid, busy, wr, _rd, d_out, d_oe
    );
endinterface

// File: rtl/ft245_ctrl.sv
// FT245 USB FIFO sequencer: arbitrates CPU byte writes/reads and generates
// the wr/_rd strobes, bus output enable and recovery gap, all outputs registered.
module ft245_ctrl #(
    parameter int WR_PULSE = 2,
    parameter int RD_PULSE = 3,
    parameter int RECOVER  = 3
) (
    input logic          clk,
    input logic          reset,
    ft245_ctrl_if.slave  bus
);

    localparam int MAXP = (WR_PULSE > RD_PULSE)
                        ? ((WR_PULSE > RECOVER) ? WR_PULSE : RECOVER)
                        : ((RD_PULSE > RECOVER) ? RD_PULSE : RECOVER);
    localparam int CW = $clog2(MAXP) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_WR_HOLD,
        ST_RD_STROBE,
        ST_RD_DONE,
        ST_RECOVER
    } state_t;

    typedef enum logic {
        RR_TX,
        RR_RX
    } rr_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    rr_t           rr_last_q, rr_last_d;

    logic txe_s1_q, txe_s_q;
    logic rdf_s1_q, rdf_s_q;

    logic       wr_q, wr_d;
    logic       rd_n_q, rd_n_d;
    logic       d_oe_q, d_oe_d;
    logic [7:0] d_out_q, d_out_d;
    logic       tx_ack_q, tx_ack_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       busy_q, busy_d;

    logic tx_elig, rx_elig, grant_tx, grant_rx;

    assign tx_elig  = bus.tx_req & ~txe_s_q;
    assign rx_elig  = bus.rx_req & ~rdf_s_q;
    // TX wins a tie only when RX was the last one served.
    assign grant_tx = tx_elig & (~rx_elig | (rr_last_q == RR_RX));
    assign grant_rx = rx_elig & ~grant_tx;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        rr_last_d  = rr_last_q;
        wr_d       = 1'b0;
        rd_n_d     = 1'b1;
        d_oe_d     = d_oe_q;
        d_out_d    = d_out_q;
        tx_ack_d   = 1'b0;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (grant_tx) begin
                    state_d   = ST_WR_SETUP;
                    rr_last_d = RR_TX;
                    d_out_d   = bus.tx_data;
                    d_oe_d    = 1'b1;
                end else if (grant_rx) begin
                    state_d   = ST_RD_STROBE;
                    rr_last_d = RR_RX;
                    rd_n_d    = 1'b0;
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_STROBE;
                cnt_d   = '0;
                wr_d    = 1'b1;
            end
            ST_WR_STROBE: begin
                if (cnt_q == CW'(WR_PULSE - 1)) begin
                    state_d  = ST_WR_HOLD;
                    cnt_d    = '0;
                    tx_ack_d = 1'b1;
                end else begin
                    wr_d = 1'b1;
                end
            end
            ST_WR_HOLD: begin
                state_d = ST_RECOVER;
                cnt_d   = '0;
                d_oe_d  = 1'b0;
            end
            ST_RD_STROBE: begin
                // d_in is taken at the edge closing the last low cycle of _rd.
                if (cnt_q == CW'(RD_PULSE - 1)) begin
                    state_d    = ST_RD_DONE;
                    cnt_d      = '0;
                    rx_data_d  = bus.d_in;
                    rx_valid_d = 1'b1;
                end else begin
                    rd_n_d = 1'b0;
                end
            end
            ST_RD_DONE: begin
                state_d = ST_RECOVER;
                cnt_d   = '0;
            end
            ST_RECOVER: begin
                if (cnt_q == CW'(RECOVER - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                d_oe_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rr_last_q  <= RR_RX;
            txe_s1_q   <= 1'b1;
            txe_s_q    <= 1'b1;
            rdf_s1_q   <= 1'b1;
            rdf_s_q    <= 1'b1;
            wr_q       <= 1'b0;
            rd_n_q     <= 1'b1;
            d_oe_q     <= 1'b0;
            d_out_q    <= '0;
            tx_ack_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_last_q  <= rr_last_d;
            txe_s1_q   <= bus._txe;
            txe_s_q    <= txe_s1_q;
            rdf_s1_q   <= bus._rdf;
            rdf_s_q    <= rdf_s1_q;
            wr_q       <= wr_d;
            rd_n_q     <= rd_n_d;
            d_oe_q     <= d_oe_d;
            d_out_q    <= d_out_d;
            tx_ack_q   <= tx_ack_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.wr       = wr_q;
    assign bus._rd      = rd_n_q;
    assign bus.d_oe     = d_oe_q;
    assign bus.d_out    = d_out_q;
    assign bus.tx_ack   = tx_ack_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.busy     = busy_q;

    a_strobe_excl: assert property (@(posedge clk) disable iff (reset) !(wr_q && !rd_n_q));
    a_oe_vs_rd:    assert property (@(posedge clk) disable iff (reset) !(d_oe_q && !rd_n_q));

endmodule

// File: tb/tb_ft245_ctrl.sv
// Scoreboard bench for ft245_ctrl: expected bytes queued at stimulus time,
// popped when tx_ack / rx_valid appear; strobe timing measured by a monitor.
module tb_ft245_ctrl;

    localparam int WR_PULSE = 2;
    localparam int RD_PULSE = 3;
    localparam int RECOVER  = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ft245_ctrl_if bus();

    ft245_ctrl #(
        .WR_PULSE (WR_PULSE),
        .RD_PULSE (RD_PULSE),
        .RECOVER  (RECOVER)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // FIFO read-data source; advances after each completed read strobe
    logic [7:0] rx_src [8];
    int rd_idx = 0;
    assign bus.d_in = rx_src[rd_idx[2:0]];

    logic [7:0] tx_exp [$];
    logic [7:0] rx_exp [$];
    bit         order  [$];

    int cyc = 0;
    int wr_len = 0, rd_len = 0;
    int wr_rises = 0, rd_rises = 0;
    int wr_rise_cyc = 0, wr_fall_cyc = 0, oe_rise_cyc = 0;
    int last_end = -100, min_gap = 1000;
    int ack_count = 0, val_count = 0, ack_cyc = 0;
    int busy_fall_cyc = 0, busy_rises = 0;
    int overlap = 0, oe_viol = 0;
    logic [7:0] wr_byte = '0;
    logic prev_oe = 1'b0, prev_busy = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (reset) begin
            wr_len  = 0;
            rd_len  = 0;
            prev_oe = 1'b0;
        end else begin
            if (bus.wr && !bus._rd) overlap++;
            if (bus.d_oe && !bus._rd) oe_viol++;
            if (bus.d_oe && !prev_oe) oe_rise_cyc = cyc;
            prev_oe = bus.d_oe;

            if (bus.wr) begin
                if (wr_len == 0) begin
                    wr_rises++;
                    wr_rise_cyc = cyc;
                    order.push_back(1'b0);
                    if (cyc - last_end < min_gap) min_gap = cyc - last_end;
                    check("setup_to_wr", cyc - oe_rise_cyc, 1);
                end
                wr_len++;
                wr_byte = bus.d_out;
            end else if (wr_len != 0) begin
                check("wr_width", wr_len, WR_PULSE);
                wr_len = 0;
                wr_fall_cyc = cyc;
                last_end = cyc;
            end

            if (!bus._rd) begin
                if (rd_len == 0) begin
                    rd_rises++;
                    order.push_back(1'b1);
                    if (cyc - last_end < min_gap) min_gap = cyc - last_end;
                end
                rd_len++;
            end else if (rd_len != 0) begin
                check("rd_width", rd_len, RD_PULSE);
                rd_len = 0;
                rd_idx++;
                last_end = cyc;
            end

            if (bus.tx_ack) begin
                ack_count++;
                ack_cyc = cyc;
                check("ack_after_wr_fall", cyc - wr_fall_cyc, 0);
                check("hold_oe", bus.d_oe, 1);
                if (tx_exp.size() == 0) check("tx_unexpected", 1, 0);
                else check("tx_byte", wr_byte, tx_exp.pop_front());
            end

            if (bus.rx_valid) begin
                val_count++;
                if (rx_exp.size() == 0) check("rx_unexpected", 1, 0);
                else check("rx_byte", bus.rx_data, rx_exp.pop_front());
            end
        end
        if (prev_busy && !bus.busy) busy_fall_cyc = cyc;
        if (!prev_busy && bus.busy) busy_rises++;
        prev_busy = bus.busy;
    end

    task automatic wait_ack(input int target);
        for (int n = 0; n < 200 && ack_count < target; n++) @(negedge clk);
        check("ack_count", ack_count, target);
    endtask

    task automatic wait_valid(input int target);
        for (int n = 0; n < 200 && val_count < target; n++) @(negedge clk);
        check("valid_count", val_count, target);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200 && bus.busy; n++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base_ack, base_val, base_ord, base_wr, base_busy, t0;
        logic [7:0] r0, r1;
        bit exp_order [4];

        rx_src = '{8'hA5, 8'h3C, 8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h81, 8'h7E};
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
        reset = 1'b1;
        bus.tx_req = 1'b0; bus.rx_req = 1'b0;
        bus.tx_data = '0;
        bus._txe = 1'b1; bus._rdf = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_wr", bus.wr, 0);
        check("rst_rd", bus._rd, 1);
        check("rst_oe", bus.d_oe, 0);
        check("rst_dout", bus.d_out, 0);
        check("rst_ack", bus.tx_ack, 0);
        check("rst_valid", bus.rx_valid, 0);
        check("rst_rxdata", bus.rx_data, 0);
        check("rst_busy", bus.busy, 0);
        reset = 1'b0;

        // Single write
        bus._txe = 1'b0;
        repeat (4) @(negedge clk);
        tx_exp.push_back(8'h23);
        bus.tx_data = 8'h23;
        bus.tx_req = 1'b1;
        wait_ack(1);
        bus.tx_req = 1'b0;
        wait_idle();
        check("busy_after_ack", busy_fall_cyc - ack_cyc, RECOVER + 1);

        // Single read
        bus._rdf = 1'b0;
        repeat (4) @(negedge clk);
        rx_exp.push_back(rx_src[rd_idx[2:0]]);
        bus.rx_req = 1'b1;
        wait_valid(1);
        bus.rx_req = 1'b0;
        check("read_rxdata_val", bus.rx_data, 8'hA5);
        wait_idle();

        // Contention: alternating grants
        base_ack = ack_count; base_val = val_count; base_ord = order.size();
        r0 = rx_src[rd_idx[2:0]]; r1 = rx_src[(rd_idx + 1) & 7];
        tx_exp.push_back(8'h11); tx_exp.push_back(8'h22);
        rx_exp.push_back(r0);    rx_exp.push_back(r1);
        bus.tx_data = 8'h11;
        bus.tx_req = 1'b1; bus.rx_req = 1'b1;
        for (int n = 0; n < 300 && (bus.tx_req || bus.rx_req); n++) begin
            @(negedge clk);
            if (ack_count - base_ack >= 1) bus.tx_data = 8'h22;
            if (ack_count - base_ack >= 2) bus.tx_req = 1'b0;
            if (val_count - base_val >= 2) bus.rx_req = 1'b0;
        end
        check("cont_acks", ack_count - base_ack, 2);
        check("cont_valids", val_count - base_val, 2);
        check("cont_order_len", order.size() - base_ord, 4);
        if (order.size() >= base_ord + 4)
            for (int k = 0; k < 4; k++) check("cont_order", order[base_ord + k], exp_order[k]);
        check("min_gap_ok", min_gap >= RECOVER, 1);
        wait_idle();

        // Flag gating
        bus._txe = 1'b1;
        repeat (4) @(negedge clk);
        base_wr = wr_rises;
        tx_exp.push_back(8'h5C);
        bus.tx_data = 8'h5C;
        bus.tx_req = 1'b1;
        repeat (10) @(negedge clk);
        check("gated_no_wr", wr_rises, base_wr);
        bus._txe = 1'b0;
        t0 = cyc;
        for (int n = 0; n < 50 && wr_rises == base_wr; n++) @(negedge clk);
        check("gate_latency", wr_rise_cyc - t0, 4);
        wait_ack(ack_count + 1);
        bus.tx_req = 1'b0;
        wait_idle();

        // Reset in the first wr-high cycle
        base_ack = ack_count;
        base_wr = wr_rises;
        bus.tx_data = 8'h77;
        bus.tx_req = 1'b1;
        for (int n = 0; n < 50 && wr_rises == base_wr; n++) @(negedge clk);
        check("abort_wr_seen", wr_rises, base_wr + 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_wr", bus.wr, 0);
        check("abort_oe", bus.d_oe, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_rxdata", bus.rx_data, 0);
        check("abort_no_ack", ack_count, base_ack);
        tx_exp.push_back(8'h77);
        reset = 1'b0;
        wait_ack(base_ack + 1);
        bus.tx_req = 1'b0;
        wait_idle();

        // One-cycle request while eligible still completes
        base_ack = ack_count;
        tx_exp.push_back(8'h9E);
        bus.tx_data = 8'h9E;
        bus.tx_req = 1'b1;
        @(negedge clk);
        bus.tx_req = 1'b0;
        wait_ack(base_ack + 1);
        repeat (20) @(negedge clk);
        check("pulse_single_ack", ack_count, base_ack + 1);

        // One-cycle request while not eligible does nothing
        bus._txe = 1'b1;
        repeat (4) @(negedge clk);
        base_wr = wr_rises; base_busy = busy_rises; base_ack = ack_count;
        bus.tx_data = 8'hE1;
        bus.tx_req = 1'b1;
        @(negedge clk);
        bus.tx_req = 1'b0;
        repeat (15) @(negedge clk);
        check("blocked_no_wr", wr_rises, base_wr);
        check("blocked_no_busy", busy_rises, base_busy);
        check("blocked_no_ack", ack_count, base_ack);

        check("wr_rd_overlap", overlap, 0);
        check("oe_during_rd", oe_viol, 0);
        check("tx_queue_empty", tx_exp.size(), 0);
        check("rx_queue_empty", rx_exp.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
